// File: rtl/img2col_feeder.sv
// img2col_feeder: loads one col_len-pixel column per round into the PU new-data register file,
// fires start and waits for pu_ack. Optional build macro IMG2COL_FEEDER_PAD_EN adds pad_col zero-padding.
module img2col_feeder #(
    parameter int data_width  = 16,
    parameter int col_len     = 5,
    parameter int address_num = 5
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    go,
    input  logic [5:0]              cfg_rounds,
    input  logic                    s_valid,
    input  logic [2*data_width-1:0] s_data,
    output logic                    s_ready,
`ifdef IMG2COL_FEEDER_PAD_EN
    input  logic                    pad_col,
`endif
    input  logic                    pu_ack,
    output logic [data_width-1:0]   new1,
    output logic [data_width-1:0]   new2,
    output logic [address_num-1:0]  adrs_in1,
    output logic [address_num-1:0]  adrs_in2,
    output logic                    wr_ctrl_g,
    output logic                    start,
    output logic [5:0]              round,
    output logic                    busy,
    output logic                    done
);

    localparam int                     BEATS   = (col_len + 1) / 2;
    localparam logic [address_num-1:0] LAST_K  = address_num'(BEATS - 1);
    localparam bit                     ODD_LEN = (col_len % 2) == 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_FIRE  = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    state_t                   state_r, state_s;
    logic [address_num-1:0]   k_r, k_s;
    logic [5:0]               round_r, round_s;
    logic [5:0]               rounds_r, rounds_s;
    logic                     pad_r, pad_s;
    logic                     wr_r, wr_s;
    logic                     start_r, start_s;
    logic                     done_r, done_s;
    logic                     busy_r, busy_s;
    logic [data_width-1:0]    new1_r, new1_s, new2_r, new2_s;
    logic [address_num-1:0]   adrs1_r, adrs1_s, adrs2_r, adrs2_s;

    logic                     pad_in_s;
    logic                     beat_s;
    logic                     last_beat_s;
    logic [address_num-1:0]   adrs_even_s, adrs_odd_s;
    logic [data_width-1:0]    lo_s, hi_s;

`ifdef IMG2COL_FEEDER_PAD_EN
    assign pad_in_s = pad_col;
`else
    assign pad_in_s = 1'b0;
`endif

    // A padded column advances one internal beat per cycle instead of waiting on the stream.
    assign beat_s      = pad_r || s_valid;
    assign last_beat_s = (k_r == LAST_K);
    assign adrs_even_s = {k_r[address_num-2:0], 1'b0};
    assign adrs_odd_s  = {k_r[address_num-2:0], 1'b1};
    assign lo_s        = pad_r ? {data_width{1'b0}} : s_data[data_width-1:0];
    assign hi_s        = pad_r ? {data_width{1'b0}} : s_data[2*data_width-1:data_width];

    assign s_ready   = (state_r == ST_LOAD) && !pad_r;
    assign new1      = new1_r;
    assign new2      = new2_r;
    assign adrs_in1  = adrs1_r;
    assign adrs_in2  = adrs2_r;
    assign wr_ctrl_g = wr_r;
    assign start     = start_r;
    assign round     = round_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // Next-state and next-output decode
    always_comb begin
        state_s  = state_r;
        k_s      = k_r;
        round_s  = round_r;
        rounds_s = rounds_r;
        pad_s    = pad_r;
        wr_s     = 1'b0;
        start_s  = 1'b0;
        done_s   = 1'b0;
        new1_s   = new1_r;
        new2_s   = new2_r;
        adrs1_s  = adrs1_r;
        adrs2_s  = adrs2_r;
        case (state_r)
            ST_IDLE: begin
                if (go) begin
                    rounds_s = cfg_rounds;
                    round_s  = 6'd0;
                    k_s      = {address_num{1'b0}};
                    if (cfg_rounds == 6'd0) begin
                        done_s = 1'b1;
                    end else begin
                        state_s = ST_LOAD;
                        pad_s   = pad_in_s;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (beat_s) begin
                    wr_s    = 1'b1;
                    new1_s  = lo_s;
                    adrs1_s = adrs_even_s;
                    // Odd tail: duplicate the first pixel so the second port rewrites the same entry.
                    if (last_beat_s && ODD_LEN) begin
                        new2_s  = lo_s;
                        adrs2_s = adrs_even_s;
                    end else begin
                        new2_s  = hi_s;
                        adrs2_s = adrs_odd_s;
                    end
                    if (last_beat_s) begin
                        state_s = ST_FLUSH;
                        k_s     = {address_num{1'b0}};
                    end else begin
                        k_s = k_r + {{(address_num-1){1'b0}}, 1'b1};
                    end
                end else begin
                    wr_s = 1'b0;
                end
            end
            ST_FLUSH: begin
                state_s = ST_FIRE;
                start_s = 1'b1;
            end
            ST_FIRE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (pu_ack) begin
                    if (round_r == rounds_r - 6'd1) begin
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        round_s = round_r + 6'd1;
                        k_s     = {address_num{1'b0}};
                        state_s = ST_LOAD;
                        pad_s   = pad_in_s;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Counters, captured configuration and registered outputs
    always_ff @(posedge clk) begin
        if (nrst) begin
            k_r      <= {address_num{1'b0}};
            round_r  <= 6'd0;
            rounds_r <= 6'd0;
            pad_r    <= 1'b0;
            wr_r     <= 1'b0;
            start_r  <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            new1_r   <= {data_width{1'b0}};
            new2_r   <= {data_width{1'b0}};
            adrs1_r  <= {address_num{1'b0}};
            adrs2_r  <= {address_num{1'b0}};
        end else begin
            k_r      <= k_s;
            round_r  <= round_s;
            rounds_r <= rounds_s;
            pad_r    <= pad_s;
            wr_r     <= wr_s;
            start_r  <= start_s;
            done_r   <= done_s;
            busy_r   <= busy_s;
            new1_r   <= new1_s;
            new2_r   <= new2_s;
            adrs1_r  <= adrs1_s;
            adrs2_r  <= adrs2_s;
        end
    end

endmodule

// File: tb/tb_img2col_feeder.sv
// Randomized self-checking bench for img2col_feeder against an event-level reference model.
module tb_img2col_feeder;

    localparam int DW    = 16;
    localparam int CL    = 5;
    localparam int AN    = 5;
    localparam int BEATS = (CL + 1) / 2;
`ifdef IMG2COL_FEEDER_PAD_EN
    localparam int PAD_PCT = 40;
`else
    localparam int PAD_PCT = 0;
`endif

    logic          clk        = 1'b0;
    logic          nrst       = 1'b1;
    logic          go         = 1'b0;
    logic [5:0]    cfg_rounds = 6'd0;
    logic          s_valid    = 1'b0;
    logic [31:0]   s_data     = 32'd0;
    logic          pu_ack     = 1'b0;
    logic          s_ready, wr_ctrl_g, start, busy, done;
    logic [DW-1:0] new1, new2;
    logic [AN-1:0] adrs_in1, adrs_in2;
    logic [5:0]    round;
    bit            pad_req = 1'b0;
`ifdef IMG2COL_FEEDER_PAD_EN
    logic          pad_col;
    assign pad_col = pad_req;
`endif

    img2col_feeder #(.data_width(DW), .col_len(CL), .address_num(AN)) dut (
        .clk(clk), .nrst(nrst), .go(go), .cfg_rounds(cfg_rounds),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
`ifdef IMG2COL_FEEDER_PAD_EN
        .pad_col(pad_col),
`endif
        .pu_ack(pu_ack), .new1(new1), .new2(new2), .adrs_in1(adrs_in1), .adrs_in2(adrs_in2),
        .wr_ctrl_g(wr_ctrl_g), .start(start), .round(round), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: what the outputs must show at the next falling edge.
    bit            m_ready, m_busy, m_load, m_pad, m_wr, m_waiting, m_rst, last_hs;
    int            m_beats, m_round, m_rounds, m_wait_cyc;
    int            m_start_at = -1;
    int            m_done_at  = -1;
    logic [AN-1:0] m_a1, m_a2;
    logic [DW-1:0] m_n1, m_n2;
    int            n_start, n_done, n_wr;
    logic [31:0]   dir_q[$];
    bit            vpat[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic enter_load();
        m_load  = 1'b1;
        m_beats = 0;
        m_pad   = pad_req;
        m_ready = !pad_req;
        m_busy  = 1'b1;
    endtask

    // Apply the currently driven inputs for one clock, then check the DUT on the falling edge.
    task automatic tick();
        bit            hs, pb;
        int            j;
        logic [DW-1:0] lo, hi;
        hs      = m_ready && s_valid;
        pb      = m_load && m_pad;
        last_hs = hs;
        m_rst   = nrst;
        m_wr    = 1'b0;
        if (nrst) begin
            m_ready = 1'b0; m_busy = 1'b0; m_load = 1'b0; m_pad = 1'b0; m_waiting = 1'b0;
            m_round = 0; m_start_at = -1; m_done_at = -1;
        end else begin
            if (hs || pb) begin
                j  = m_beats;
                lo = m_pad ? {DW{1'b0}} : s_data[DW-1:0];
                hi = m_pad ? {DW{1'b0}} : s_data[2*DW-1:DW];
                m_a1 = AN'(2 * j);
                m_n1 = lo;
                if (2 * j + 1 < CL) begin
                    m_a2 = AN'(2 * j + 1);
                    m_n2 = hi;
                end else begin
                    m_a2 = AN'(2 * j);
                    m_n2 = lo;
                end
                m_wr = 1'b1;
                m_beats++;
                if (m_beats == BEATS) begin
                    m_load     = 1'b0;
                    m_ready    = 1'b0;
                    m_start_at = cyc + 2;
                end
            end
            if (go && !m_busy) begin
                m_rounds = int'(cfg_rounds);
                m_round  = 0;
                if (cfg_rounds == 6'd0) m_done_at = cyc + 1;
                else enter_load();
            end
            if (pu_ack && m_waiting) begin
                m_waiting = 1'b0;
                if (m_round == m_rounds - 1) begin
                    m_busy    = 1'b0;
                    m_done_at = cyc + 1;
                end else begin
                    m_round++;
                    enter_load();
                end
            end
        end
        @(negedge clk);
        cyc++;
        if (m_start_at >= 0 && cyc == m_start_at + 1) begin
            m_waiting  = 1'b1;
            m_wait_cyc = 0;
        end else if (m_waiting) begin
            m_wait_cyc++;
        end
        check_val("s_ready", s_ready, m_ready);
        check_val("busy", busy, m_busy);
        check_val("wr_ctrl_g", wr_ctrl_g, m_wr);
        if (m_wr) begin
            check_val("adrs_in1", adrs_in1, m_a1);
            check_val("adrs_in2", adrs_in2, m_a2);
            check_val("new1", new1, m_n1);
            check_val("new2", new2, m_n2);
        end
        check_val("start", start, cyc == m_start_at);
        if (cyc == m_start_at) check_val("round", round, m_round);
        check_val("done", done, cyc == m_done_at);
        if (m_rst) begin
            check_val("rst_new1", new1, 0);
            check_val("rst_new2", new2, 0);
            check_val("rst_adrs_in1", adrs_in1, 0);
            check_val("rst_adrs_in2", adrs_in2, 0);
            check_val("rst_round", round, 0);
        end
        if (start) n_start++;
        if (done) n_done++;
        if (wr_ctrl_g) n_wr++;
    endtask

    task automatic run_job(input int rounds, input int vpct, input int ack_lat, input int pad_pct,
                           input int rst_beat);
        int bound;
        bound   = 0;
        n_start = 0;
        n_done  = 0;
        n_wr    = 0;
        cfg_rounds = 6'(rounds);
        go      = 1'b1;
        s_valid = 1'b0;
        pu_ack  = 1'b0;
        pad_req = ($urandom_range(99) < pad_pct);
        tick();
        go = 1'b0;
        while ((m_busy || m_done_at > cyc) && bound < 3000) begin
            bound++;
            if (rst_beat >= 0 && m_round == 0 && m_load && m_beats == rst_beat) begin
                nrst = 1'b1; s_valid = 1'b1; go = 1'b0; pu_ack = 1'b0;
                tick();
                nrst = 1'b0; s_valid = 1'b0;
                return;
            end
            if (m_ready && vpat.size() > 0) s_valid = vpat.pop_front();
            else s_valid = ($urandom_range(99) < vpct);
            s_data     = (dir_q.size() > 0) ? dir_q[0] : $urandom;
            cfg_rounds = 6'($urandom_range(63));
            go         = m_busy && ($urandom_range(9) == 0);
            pu_ack     = m_waiting ? (m_wait_cyc >= ack_lat) : ($urandom_range(7) == 0);
            pad_req    = ($urandom_range(99) < pad_pct);
            tick();
            if (last_hs && dir_q.size() > 0) void'(dir_q.pop_front());
        end
        go = 1'b0; pu_ack = 1'b0; s_valid = 1'b0;
        check_val("timeout", bound >= 3000, 0);
        check_val("start_count", n_start, rounds);
        check_val("done_count", n_done, 1);
        check_val("write_count", n_wr, rounds * BEATS);
    endtask

    initial begin
        tick();
        tick();
        nrst = 1'b0;
        tick();
        // Directed column with odd tail and an immediate acknowledge
        dir_q = '{32'h0002_0001, 32'h0004_0003, 32'hFFFF_0005};
        run_job(1, 100, 0, 0, -1);
        // Three rounds with a slow PU
        run_job(3, 100, 10, 0, -1);
        // Stream gaps during the load
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run_job(1, 50, 0, 0, -1);
        // Reset in the middle of the first column, then restart
        run_job(2, 100, 0, 0, 2);
        run_job(1, 100, 0, 0, -1);
        // Zero-round job
        run_job(0, 100, 0, 0, -1);
`ifdef IMG2COL_FEEDER_PAD_EN
        run_job(1, 100, 0, 100, -1);
        run_job(1, 100, 0, 0, -1);
`endif
        for (int i = 0; i < 10; i++) begin
            run_job($urandom_range(4, 1), $urandom_range(100, 30), $urandom_range(5, 0), PAD_PCT, -1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/img2col_feeder.md
# img2col_feeder

Upstream stage of the img2col processing unit. Takes a two-pixel-per-beat valid/ready stream from the AXI read path and writes one column of `col_len` pixels per round into the PU's 5-entry new-data register file. It drives `new1`/`new2`, `adrs_in1`/`adrs_in2` and `wr_ctrl_g`, then pulses `start` with the current `round` index. It waits for the PU to acknowledge before loading the next column, and signals `done` after the configured number of rounds.

## Interface
- `data_width`, 16, pixel width
- `col_len`, 5, pixels written per round (1..2**address_num)
- `address_num`, 5, address width toward the new-data register file
- `clk`  in  1  clock, rising edge
- `nrst`  in  1  reset, synchronous, active-high (reset when `nrst`=1)
- `go`  in  1  start a job; sampled in IDLE only
- `cfg_rounds`  in  6  rounds per job; captured on `go`
- `s_valid`  in  1  stream beat valid
- `s_data`  in  2*data_width  low half = first pixel, high half = second pixel
- `s_ready`  out  1  stream beat accepted when `s_valid`&&`s_ready`
- `pu_ack`  in  1  PU finished consuming the current round
- `new1`, `new2`  out  data_width  write data
- `adrs_in1`, `adrs_in2`  out  address_num  write addresses
- `wr_ctrl_g`  out  1  write enable for the new-data register file
- `start`  out  1  one-cycle pulse: column loaded
- `round`  out  6  index of the round being loaded/processed
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle pulse after the last round's `pu_ack`

## Operation
- FSM states: IDLE, LOAD, FLUSH, FIRE, WAIT.
- **IDLE:** `s_ready`=0. `go`=1 captures `cfg_rounds` and clears `round`. With `cfg_rounds`=0, `done` pulses next cycle and the FSM stays in IDLE. Otherwise go to LOAD.
- **LOAD:** `s_ready`=1. The beat counter `k` runs 0..ceil(col_len/2)-1. Each handshake registers:
  - `new1`=low half, `new2`=high half, `adrs_in1`=2k, `adrs_in2`=2k+1, `wr_ctrl_g`=1 for the next cycle.
  - When col_len is odd, on the final beat the high half is ignored: `new2`=`new1` and `adrs_in2`=`adrs_in1`. This makes the duplicate write identical.
  - The handshake of the last beat moves the FSM to FLUSH.
- **FLUSH:** one cycle. `s_ready`=0; the last registered write is presented (`wr_ctrl_g`=1).
- **FIRE:** `start`=1 for one cycle, `wr_ctrl_g`=0, then go to WAIT.
- **WAIT:** hold until `pu_ack`=1.
  - If `round`==`cfg_rounds`-1: pulse `done`, go to IDLE.
  - Otherwise increment `round`, reset `k`, go to LOAD.
  - `pu_ack` outside WAIT is ignored.
- `go` outside IDLE is ignored. `cfg_rounds` changes after capture have no effect.
- Reset (any state, mid-column included): state=IDLE, `k`=0, `round`=0. All outputs 0: `s_ready`, `wr_ctrl_g`, `start`, `busy`, `done`, `new1`, `new2`, `adrs_in1`, `adrs_in2`. A partially loaded column is abandoned and its beats are not replayed.

## Timing
- All outputs are registered; no combinational path from inputs to outputs except `s_ready`, which is decoded from the state register only.
- Beat accepted at cycle t gives `wr_ctrl_g`/data/addresses valid at t+1.
- Last beat accepted at t: final write at t+1 (FLUSH), `start` at t+2 (FIRE), WAIT from t+3.
- Minimum column load is ceil(col_len/2) cycles; `s_valid` gaps stretch LOAD cycle for cycle.
- `pu_ack` seen at cycle w: LOAD (`s_ready`=1) or `done`=1 at w+1.
- Minimum round period for col_len=5 with zero stalls: 3 + 1 + 1 + 1 = 6 cycles.

## Configuration
- `IMG2COL_FEEDER_PAD_EN`
  - **Defined:** adds input `pad_col` (1 bit), sampled on entry to LOAD. When `pad_col`=1, LOAD keeps `s_ready`=0 and internally generates the same ceil(col_len/2) writes with `new1`=`new2`=0, one per cycle. Addresses and the odd-tail rule are unchanged. This zero-pads image borders without consuming stream beats.
  - **Undefined:** the port is absent and every column is taken from the stream.

## Test plan
- Reset, then `go` with `cfg_rounds`=1 and beats {0x0002_0001, 0x0004_0003, 0xFFFF_0005}, no stalls:
  - writes (0,1)=(1,2), (2,3)=(3,4), (4,4)=(5,5);
  - `start` two cycles after the third beat; after `pu_ack`, `done` one cycle later.
- `cfg_rounds`=3 with `pu_ack` delayed 10 cycles each round: `round` reads 0, 1, 2 at each `start`; exactly three `start` pulses and one `done`.
- `s_valid` toggled 1,0,0,1,0,1: exactly 3 writes, each one cycle after its handshake; `wr_ctrl_g`=0 during gaps.
- `nrst`=1 after the second beat of round 0: all outputs 0 next cycle. A new `go` restarts at `adrs_in1`=0, `round`=0.
- `cfg_rounds`=0: `done` pulses once, no `wr_ctrl_g`, no `start`, `s_ready` stays 0.
- With `IMG2COL_FEEDER_PAD_EN`, `pad_col`=1: three zero writes with `s_ready`=0 throughout, then `start`; the stream beat held valid is consumed in the next unpadded round.
